// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: FSM state encodings, default
// reset PC and timeout, the memory-request bundle, and the next-PC helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FU_RESET_PC = 32'h0000_0000;
    localparam int          FU_TIMEOUT  = 16;

    // Outstanding instruction-memory read.
    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
    } mem_req_t;

    // Sequential or relative next PC; all arithmetic wraps modulo 2^32 and
    // the shifted immediate loses whatever falls off bit 31.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic        sel,
                                            input logic [31:0] immed);
        logic [31:0] ofs;
        ofs = sel ? (immed << 2) : 32'd0;
        return pc + 32'd4 + ofs;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with next-PC adder.
// Ports:
//   Clk, Reset_n   clock, async active-low reset (PC <= RESET_PC)
//   ld_en          load enable (already qualified by the caller)
//   pc_sel         0: PC+4, 1: PC+4+(immed<<2)
//   immed          sign-extended immediate
//   pc             current PC
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FU_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ld_en,
    input  logic        pc_sel,
    input  logic [31:0] immed,
    output logic [31:0] pc
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)   pc <= RESET_PC;
        else if (ld_en) pc <= next_pc(pc, pc_sel, immed);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read per Fetch_req,
// captures the returned word into the IR, and faults (terminally, until
// reset) on a misaligned PC or a memory that never acknowledges.
// Ports:
//   Clk, Reset_n        clock, async active-low reset
//   Fetch_req           fetch the word at PC (accepted in IDLE only)
//   PC_LdEn/PC_sel/Immed  PC update controls (accepted in IDLE only)
//   Mem_data, Mem_ack   memory read return
//   Mem_rd, Mem_addr    memory read request
//   Instr, Instr_valid  IR contents and one-cycle capture pulse
//   PC                  current PC
//   Busy, Fault         not-IDLE status and sticky error flag
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FU_RESET_PC,
    parameter int          TIMEOUT  = FU_TIMEOUT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Fetch_req,
    input  logic        PC_LdEn,
    input  logic        PC_sel,
    input  logic [31:0] Immed,
    input  logic [31:0] Mem_data,
    input  logic        Mem_ack,
    output logic        Mem_rd,
    output logic [31:0] Mem_addr,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] PC,
    output logic        Busy,
    output logic        Fault
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t     state, state_nx;
    mem_req_t         req;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ir;
    logic             ivalid;
    logic             fault_q;
    logic             start, capture;

    // PC only moves while idle; a fetch sampled on the same edge already
    // latched the old PC into the request.
    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .ld_en   (PC_LdEn && (state == ST_IDLE)),
        .pc_sel  (PC_sel),
        .immed   (Immed),
        .pc      (PC)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Fetch_req) begin
                    if (PC[1:0] == 2'b00) begin
                        start    = 1'b1;
                        state_nx = ST_WAIT;
                    end else begin
                        state_nx = ST_FAULT;
                    end
                end
            end
            ST_WAIT: begin
                if (Mem_ack) begin
                    capture  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_FAULT: state_nx = ST_FAULT;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            req     <= '0;
            cnt     <= '0;
            ir      <= '0;
            ivalid  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ivalid <= capture;
            if (start) begin
                req.rd   <= 1'b1;
                req.addr <= PC;
                cnt      <= '0;
            end
            if (capture) begin
                ir     <= Mem_data;
                req.rd <= 1'b0;
            end
            // Count only ack-less cycles that stay in WAIT.
            if (state == ST_WAIT && state_nx == ST_WAIT)
                cnt <= cnt + CNT_W'(1);
            if (state != ST_FAULT && state_nx == ST_FAULT) begin
                fault_q <= 1'b1;
                req.rd  <= 1'b0;
            end
        end
    end

    assign Mem_rd      = req.rd;
    assign Mem_addr    = req.addr;
    assign Instr       = ir;
    assign Instr_valid = ivalid;
    assign Busy        = (state != ST_IDLE);
    assign Fault       = fault_q;

endmodule
